// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcode/func fields and datapath select codes.
// Pure definitions; no logic, no latency.
package mc_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MDWAIT = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_NOP   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_BRANCH = 2'b01;
    localparam logic [1:0] NPC_JUMP   = 2'b10;

    localparam logic [1:0] NPCIMM_NONE  = 2'b00;
    localparam logic [1:0] NPCIMM_IMM26 = 2'b01;
    localparam logic [1:0] NPCIMM_RS    = 2'b10;

    localparam logic [1:0] A3_RT = 2'b00;
    localparam logic [1:0] A3_RD = 2'b01;
    localparam logic [1:0] A3_RA = 2'b10;

    localparam logic [2:0] WD_ALU = 3'd0;
    localparam logic [2:0] WD_DM  = 3'd1;
    localparam logic [2:0] WD_EXT = 3'd2;
    localparam logic [2:0] WD_PC4 = 3'd3;
    localparam logic [2:0] WD_HI  = 3'd4;
    localparam logic [2:0] WD_LO  = 3'd5;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;

    localparam logic [2:0] EXT_ZERO = 3'd0;
    localparam logic [2:0] EXT_SIGN = 3'd1;
    localparam logic [2:0] EXT_LUI  = 3'd2;

    // One-hot instruction class; exactly one field is set for any opcode/func pair.
    typedef struct packed {
        logic addu;
        logic subu;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic jal;
        logic jr;
        logic mult;
        logic div;
        logic mfhi;
        logic mflo;
        logic nop;
    } inst_cls_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/func to one-hot instruction class; unknown encodings map to nop.
// Zero latency, no flow control.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output inst_cls_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADDU: cls.addu = 1'b1;
                    FN_SUBU: cls.subu = 1'b1;
                    FN_JR:   cls.jr   = 1'b1;
                    FN_MULT: cls.mult = 1'b1;
                    FN_DIV:  cls.div  = 1'b1;
                    FN_MFHI: cls.mfhi = 1'b1;
                    FN_MFLO: cls.mflo = 1'b1;
                    default: cls.nop  = 1'b1;
                endcase
            end
            OP_ORI:  cls.ori = 1'b1;
            OP_LUI:  cls.lui = 1'b1;
            OP_LW:   cls.lw  = 1'b1;
            OP_SW:   cls.sw  = 1'b1;
            OP_BEQ:  cls.beq = 1'b1;
            OP_JAL:  cls.jal = 1'b1;
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus an MDWAIT stall for mult/div.
// 2..5 cycles per instruction, 2+latency for mult/div; outputs are combinational from state and IR fields.
module mc_controller
    import mc_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       zero,
    output logic       PCWE,
    output logic       IRWE,
    output logic       GRFWE,
    output logic       DMWE,
    output logic [1:0] NPCOp,
    output logic [1:0] NPCIMM_MUXOp,
    output logic [2:0] ALUOp,
    output logic [2:0] EXTOp,
    output logic       ALUB_MUXOp,
    output logic [1:0] GRFA3_MUXOp,
    output logic [2:0] GRFWD_MUXOp,
    output logic       MDStart,
    output logic       MDOp,
    output logic       MDBusy,
    output logic       Retire,
    output logic [2:0] State
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    inst_cls_t        cls;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_last;

    mc_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .cls    (cls)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A latency of 1 finishes inside EXEC, so MDWAIT is skipped entirely.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (cls.jal)      state_d = S_WB;
                else if (cls.nop) state_d = S_FETCH;
                else              state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cls.addu || cls.subu || cls.ori || cls.lui || cls.mfhi || cls.mflo) begin
                    state_d = S_WB;
                end else if (cls.lw || cls.sw) begin
                    state_d = S_MEM;
                end else if (cls.mult && (MULT_CYCLES > 1)) begin
                    state_d = S_MDWAIT;
                    cnt_d   = MULT_LOAD;
                end else if (cls.div && (DIV_CYCLES > 1)) begin
                    state_d = S_MDWAIT;
                    cnt_d   = DIV_LOAD;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM: state_d = cls.sw ? S_FETCH : S_WB;
            S_WB:  state_d = S_FETCH;
            S_MDWAIT: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_ONE;
                if (md_last)     state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign md_last = (cnt_q <= CNT_ONE);

    always_comb begin
        PCWE         = 1'b0;
        IRWE         = 1'b0;
        GRFWE        = 1'b0;
        DMWE         = 1'b0;
        NPCOp        = NPC_PC4;
        NPCIMM_MUXOp = NPCIMM_NONE;
        MDStart      = 1'b0;
        Retire       = 1'b0;

        // Operand selects depend only on the class and are harmless outside their state.
        ALUOp = ALU_ADD;
        if (cls.subu || cls.beq) ALUOp = ALU_SUB;
        else if (cls.ori)        ALUOp = ALU_OR;

        EXTOp = EXT_SIGN;
        if (cls.ori)      EXTOp = EXT_ZERO;
        else if (cls.lui) EXTOp = EXT_LUI;

        ALUB_MUXOp = cls.addu || cls.subu || cls.beq;

        GRFA3_MUXOp = A3_RT;
        if (cls.addu || cls.subu || cls.mfhi || cls.mflo) GRFA3_MUXOp = A3_RD;
        else if (cls.jal)                                 GRFA3_MUXOp = A3_RA;

        GRFWD_MUXOp = WD_ALU;
        if (cls.lw)        GRFWD_MUXOp = WD_DM;
        else if (cls.lui)  GRFWD_MUXOp = WD_EXT;
        else if (cls.jal)  GRFWD_MUXOp = WD_PC4;
        else if (cls.mfhi) GRFWD_MUXOp = WD_HI;
        else if (cls.mflo) GRFWD_MUXOp = WD_LO;

        MDOp   = cls.div;
        MDBusy = (state_q == S_MDWAIT);

        case (state_q)
            S_FETCH: begin
                PCWE = 1'b1;
                IRWE = 1'b1;
            end
            S_DECODE: Retire = cls.nop;
            S_EXEC: begin
                if (cls.beq) begin
                    PCWE   = zero;
                    NPCOp  = NPC_BRANCH;
                    Retire = 1'b1;
                end else if (cls.jr) begin
                    PCWE         = 1'b1;
                    NPCOp        = NPC_JUMP;
                    NPCIMM_MUXOp = NPCIMM_RS;
                    Retire       = 1'b1;
                end else if (cls.mult || cls.div) begin
                    MDStart = 1'b1;
                    Retire  = cls.mult ? (MULT_CYCLES <= 1) : (DIV_CYCLES <= 1);
                end
            end
            S_MEM: begin
                DMWE   = cls.sw;
                Retire = cls.sw;
            end
            S_WB: begin
                GRFWE  = 1'b1;
                Retire = 1'b1;
                if (cls.jal) begin
                    PCWE         = 1'b1;
                    NPCOp        = NPC_JUMP;
                    NPCIMM_MUXOp = NPCIMM_IMM26;
                end
            end
            S_MDWAIT: Retire = md_last;
            default: ;
        endcase

        if (reset) begin
            PCWE    = 1'b0;
            IRWE    = 1'b0;
            GRFWE   = 1'b0;
            DMWE    = 1'b0;
            MDStart = 1'b0;
            Retire  = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle MIPS controller. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the same datapath selects as before, plus per-state write enables. It extends the instruction set with mult/div/mfhi/mflo, and stalls on the multiply/divide unit for a parametrised latency. It sits between the IR (opcode/func fields) and the multi-cycle datapath (PC, IR, GRF, ALU, EXT, DM, MDU).

## Interface
Parameters:
- MULT_CYCLES, 5, total MDU cycles for mult; legal range is ≥1.
- DIV_CYCLES, 10, total MDU cycles for div; legal range is ≥1.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH.
- func  in  6  IR[5:0].
- zero  in  1  ALU equality flag for beq.
- PCWE  out  1  PC write enable.
- IRWE  out  1  IR write enable.
- GRFWE  out  1  register file write enable.
- DMWE  out  1  data memory write enable.
- NPCOp  out  2  next-PC select: 00 PC+4, 01 branch, 10 jump.
- NPCIMM_MUXOp  out  2  jump target select: 01 imm26 (jal), 10 rs (jr).
- ALUOp  out  3  ALU operation, same codes as the single-cycle controller.
- EXTOp  out  3  immediate extension mode, same codes as the single-cycle controller.
- ALUB_MUXOp  out  1  ALU B select: 1 rt, 0 ext.
- GRFA3_MUXOp  out  2  write-register select: 00 rt, 01 rd, 10 $31.
- GRFWD_MUXOp  out  3  write-data select: 0 ALU, 1 DM, 2 EXT, 3 PC+4, 4 HI, 5 LO.
- MDStart  out  1  one-cycle MDU start pulse.
- MDOp  out  1  0 mult, 1 div.
- MDBusy  out  1  high while in MDWAIT.
- Retire  out  1  high on the final cycle of each instruction.
- State  out  3  current state, for debug.

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5. All outputs are combinational from State, opcode and func (Moore per class).
- FETCH: PCWE=1, IRWE=1, NPCOp=00. Next state is DECODE.
- DECODE: no enables. Next state by class:
  - jal → WB.
  - nop or unknown encoding → FETCH, with Retire=1.
  - all others → EXEC.
- EXEC, by class:
  - R-type (addu/subu), ori, lui → WB.
  - lw/sw → MEM; ALU computes the address with EXTOp = sign-extend.
  - beq: PCWE=zero, NPCOp=01, Retire=1, → FETCH.
  - jr: PCWE=1, NPCOp=10, NPCIMM_MUXOp=10, Retire=1, → FETCH.
  - mult/div: MDStart=1, MDOp set. If the latency is 1 → FETCH with Retire=1; otherwise load counter with latency−1 and go to MDWAIT.
  - mfhi/mflo → WB.
- MEM:
  - sw: DMWE=1, Retire=1, → FETCH.
  - lw → WB.
- WB: GRFWE=1, Retire=1, → FETCH. GRFA3/GRFWD are set per class:
  - addu/subu: rd/ALU.
  - ori: rt/ALU.
  - lui: rt/EXT.
  - lw: rt/DM.
  - jal: $31/PC+4, plus PCWE=1, NPCOp=10, NPCIMM_MUXOp=01.
  - mfhi/mflo: rd/HI or rd/LO.
- MDWAIT: MDBusy=1. Counter decrements each cycle. When the counter is 1: Retire=1, → FETCH.
- Enables not listed for a state are 0. Unknown func under opcode 0 is treated as nop.

## Timing
- Total cycles per class: addu/subu/ori/lui 4; lw 5; sw 4; beq 3; jr 3; jal 3; mfhi/mflo 4; nop 2; mult = 2+MULT_CYCLES; div = 2+DIV_CYCLES.
- Reset: on assertion, State=FETCH and counter=0 immediately. While reset is high, all enables and MDStart are forced to 0 and Retire=0. After deassertion, the first edge performs FETCH.
- Reset mid-instruction (including MDWAIT) aborts with no further writes.
- Counter width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1). The counter never wraps; it is only loaded in EXEC.
- Exactly one Retire pulse per instruction. PCWE is asserted at most twice per instruction: FETCH, plus the branch/jump cycle.

## Structure
- Package mc_pkg holds:
  - state encodings;
  - opcode/func constants for all 14 instructions;
  - NPCOp, GRFA3 and GRFWD select codes;
  - ALUOp and EXTOp codes.
- Sub-module mc_decode is a combinational opcode/func → one-hot instruction-class decode. The top level holds the state register, MDU counter and output logic.

## Test plan
- Reset: assert reset in MDWAIT with counter=4 → State=0 the same cycle and all enables 0. After release, the next edge has PCWE=IRWE=1.
- addu (opcode 0, func 0x21) → states 0,1,2,4. WB has GRFWE=1, GRFA3=01, GRFWD=0, Retire=1, for 4 cycles total.
- lw (0x23) and sw (0x2B):
  - lw → DMWE never set; WB has GRFWD=1.
  - sw → MEM has DMWE=1, GRFWE never set.
- beq (0x04) run once with zero=1 and once with zero=0 → EXEC PCWE is 1 and 0 respectively, with NPCOp=01 in both.
- jal (0x03) → 3 cycles; WB has GRFWE=1, GRFA3=10, GRFWD=3, PCWE=1, NPCOp=10, NPCIMM=01.
- mult with MULT_CYCLES=5 and div with DIV_CYCLES=10 → MDStart is a single pulse in EXEC; MDBusy is high for 4 and 9 cycles respectively; Retire fires once. A follow-up mflo gives GRFWD=5.
